// File: rtl/sample_pkg.sv
// Shared sample-path definitions used by the ADC conditioner and the min/max envelope filter.
package sample_pkg;

    localparam int unsigned SAMPLE_DATA_WIDTH = 8;

    typedef struct packed {
        logic signed [31:0] value;
        logic               clip;
    } sat_t;

    // Clamp a signed value into a signed field of 'width' bits; clip flags any change.
    function automatic sat_t sat_signed(input logic signed [31:0] value, input int unsigned width);
        sat_t               r;
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi      = (32'sd1 <<< (width - 1)) - 32'sd1;
        lo      = -(32'sd1 <<< (width - 1));
        r.value = value;
        r.clip  = 1'b0;
        if (value > hi) begin
            r.value = hi;
            r.clip  = 1'b1;
        end else if (value < lo) begin
            r.value = lo;
            r.clip  = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/adc_sample_conditioner_if.sv
// Raw ADC input stream plus conditioned sample output stream of the conditioner.
interface adc_sample_conditioner_if #(
    parameter int unsigned ADC_WIDTH = 12,
    parameter int unsigned OUT_WIDTH = 8
);
    logic                        adc_valid;
    logic [ADC_WIDTH-1:0]        adc_data;
    logic                        dc_hold;
    logic                        axiov;
    logic signed [OUT_WIDTH-1:0] axiod;
    logic                        clipped;

    modport master (
        output adc_valid, adc_data, dc_hold,
        input  axiov, axiod, clipped
    );

    modport slave (
        input  adc_valid, adc_data, dc_hold,
        output axiov, axiod, clipped
    );
endinterface

// File: rtl/boxcar_decimator.sv
// Boxcar decimator: averages DECIMATION valid input codes into one registered output code.
module boxcar_decimator #(
    parameter int unsigned ADC_WIDTH  = 12,
    parameter int unsigned DECIMATION = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [ADC_WIDTH-1:0] in_data,
    output logic [ADC_WIDTH-1:0] avg,
    output logic                 avg_v
);
    localparam int unsigned LOG2D = $clog2(DECIMATION);
    localparam int unsigned CNT_W = (LOG2D > 0) ? LOG2D : 1;
    localparam int unsigned ACC_W = ADC_WIDTH + LOG2D;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DECIMATION - 1);

    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [ACC_W-1:0]     sum;
    logic [ADC_WIDTH-1:0] avg_q, avg_d;
    logic                 avg_v_q, avg_v_d;

    always_comb begin
        sum     = acc_q + ACC_W'(in_data);
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        avg_d   = avg_q;
        avg_v_d = 1'b0;
        if (in_valid) begin
            if (cnt_q == LAST) begin
                avg_d   = ADC_WIDTH'(sum >> LOG2D);
                avg_v_d = 1'b1;
                acc_d   = '0;
                cnt_d   = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            acc_q   <= '0;
            avg_q   <= '0;
            avg_v_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            avg_q   <= avg_d;
            avg_v_q <= avg_v_d;
        end
    end

    assign avg   = avg_q;
    assign avg_v = avg_v_q;

endmodule

// File: rtl/adc_sample_conditioner.sv
// ADC sample conditioner: decimate, remove DC with an EMA, scale and saturate to signed samples.
module adc_sample_conditioner
    import sample_pkg::*;
#(
    parameter int unsigned ADC_WIDTH  = 12,
    parameter int unsigned DECIMATION = 4,
    parameter int unsigned DC_SHIFT   = 8,
    parameter int unsigned GAIN_SHIFT = 4,
    parameter int unsigned OUT_WIDTH  = SAMPLE_DATA_WIDTH
) (
    input logic                     clk,
    input logic                     rst_n,
    adc_sample_conditioner_if.slave bus
);
    localparam int unsigned DC_W = ADC_WIDTH + DC_SHIFT;
    localparam logic [DC_W-1:0] DC_MID = DC_W'(1) << (DC_W - 1);

    logic [ADC_WIDTH-1:0]        avg;
    logic                        avg_v;
    logic [DC_W-1:0]             dc_q, dc_d;
    logic [ADC_WIDTH-1:0]        dc_int;
    logic signed [ADC_WIDTH:0]   diff;
    logic signed [ADC_WIDTH:0]   scaled;
    sat_t                        sat;
    logic                        axiov_q, axiov_d;
    logic signed [OUT_WIDTH-1:0] axiod_q, axiod_d;
    logic                        clip_q, clip_d;
    logic                        unused_sat_hi;

    boxcar_decimator #(
        .ADC_WIDTH  (ADC_WIDTH),
        .DECIMATION (DECIMATION)
    ) u_boxcar (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (bus.adc_valid),
        .in_data  (bus.adc_data),
        .avg      (avg),
        .avg_v    (avg_v)
    );

    // DC removal uses the estimate from before this cycle's EMA step.
    always_comb begin
        dc_int  = dc_q[DC_W-1:DC_SHIFT];
        diff    = $signed({1'b0, avg}) - $signed({1'b0, dc_int});
        scaled  = diff >>> GAIN_SHIFT;
        sat     = sat_signed(32'(scaled), OUT_WIDTH);
        dc_d    = dc_q;
        axiov_d = 1'b0;
        axiod_d = axiod_q;
        clip_d  = 1'b0;
        if (avg_v) begin
            if (!bus.dc_hold) begin
                dc_d = dc_q + DC_W'(avg) - DC_W'(dc_int);
            end
            axiov_d = 1'b1;
            axiod_d = sat.value[OUT_WIDTH-1:0];
            clip_d  = sat.clip;
        end
    end

    assign unused_sat_hi = ^sat.value[31:OUT_WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dc_q    <= DC_MID;
            axiov_q <= 1'b0;
            axiod_q <= '0;
            clip_q  <= 1'b0;
        end else begin
            dc_q    <= dc_d;
            axiov_q <= axiov_d;
            axiod_q <= axiod_d;
            clip_q  <= clip_d;
        end
    end

    assign bus.axiov   = axiov_q;
    assign bus.axiod   = axiod_q;
    assign bus.clipped = clip_q;

endmodule
